// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit -- iterative 32-bit integer divider (DIV / DIVU) for the EXE stage.
//
// Restoring radix-2 divider on operand magnitudes, one quotient bit per cycle.
// A request accepted in cycle 0 produces a one-cycle ready pulse in cycle 33.
// Division by zero yields quotient = 0 and remainder = 0 in both modes.
//
// Build option:
//   DIV_ZERO_EARLY_OUT_EN  defined   : divisor == 0 short-cuts through ZERO,
//                                      ready in cycle 2.
//                          undefined : divisor == 0 runs the full 32 cycles.
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rstn_i        synchronous active-low reset
//   start_i       request, accepted only in IDLE or DONE with annul_i low
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
//   dividend_i    operand A, sampled with start_i
//   divisor_i     operand B, sampled with start_i
//   annul_i       abort an in-flight divide; blocks start_i when not busy
//   busy_o        high while in CALC or ZERO
//   ready_o       one-cycle pulse in DONE; quotient_o/remainder_o valid
//   quotient_o    registered quotient (LO)
//   remainder_o   registered remainder (HI)
// -----------------------------------------------------------------------------
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             start_i,
   input  logic             signed_div_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             annul_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] ZERO = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [5:0]       cnt_q,   cnt_d;
   logic [WIDTH-1:0] rem_q,   rem_d;    // partial remainder
   logic [WIDTH-1:0] quo_q,   quo_d;    // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0] dvs_q,   dvs_d;    // divisor magnitude
   logic             qneg_q,  qneg_d;
   logic             rneg_q,  rneg_d;
   logic             dz_q,    dz_d;     // divisor was zero
   logic [WIDTH-1:0] qout_q,  qout_d;
   logic [WIDTH-1:0] rout_q,  rout_d;

   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   diff;
   logic             fits;
   logic [WIDTH-1:0] iter_rem;
   logic [WIDTH-1:0] iter_quo;
   logic             start_ok;
   logic             a_neg;
   logic             b_neg;

   // Since rem < divisor, acc < 2*divisor and the borrow bit alone tells
   // whether the trial subtraction succeeded.
   always_comb begin
      acc      = {rem_q, quo_q[WIDTH-1]};
      diff     = acc - {1'b0, dvs_q};
      fits     = ~diff[WIDTH];
      iter_rem = fits ? diff[WIDTH-1:0] : acc[WIDTH-1:0];
      iter_quo = {quo_q[WIDTH-2:0], fits};
   end

   always_comb begin
      start_ok = start_i && !annul_i && (state_q == IDLE || state_q == DONE);
      a_neg    = signed_div_i && dividend_i[WIDTH-1];
      b_neg    = signed_div_i && divisor_i[WIDTH-1];

      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      qout_d  = qout_q;
      rout_d  = rout_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_ok) begin
               cnt_d  = '0;
               rem_d  = '0;
               quo_d  = a_neg ? -dividend_i : dividend_i;
               dvs_d  = b_neg ? -divisor_i  : divisor_i;
               qneg_d = a_neg ^ b_neg;
               rneg_d = a_neg;
               dz_d   = (divisor_i == '0);
`ifdef DIV_ZERO_EARLY_OUT_EN
               state_d = (divisor_i == '0) ? ZERO : CALC;
`else
               state_d = CALC;
`endif
            end
         end
         CALC: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               rem_d = iter_rem;
               quo_d = iter_quo;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(WIDTH - 1)) begin
                  state_d = DONE;
                  // Result registers load from the final iteration directly,
                  // so they change only on entry to DONE.
                  if (dz_q) begin
                     qout_d = '0;
                     rout_d = '0;
                  end else begin
                     qout_d = qneg_q ? -iter_quo : iter_quo;
                     rout_d = rneg_q ? -iter_rem : iter_rem;
                  end
               end
            end
         end
         ZERO: begin
            if (annul_i) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
               qout_d  = '0;
               rout_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         qout_q  <= '0;
         rout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         qout_q  <= qout_d;
         rout_q  <= rout_d;
      end
   end

   assign busy_o      = (state_q == CALC) || (state_q == ZERO);
   assign ready_o     = (state_q == DONE);
   assign quotient_o  = qout_q;
   assign remainder_o = rout_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit.
// Expected results come from a reference model and are queued when a request
// is driven, then popped when ready_o pulses.
// -----------------------------------------------------------------------------
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        signed_div;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        annul;
   logic        busy;
   logic        ready;
   logic [31:0] quotient;
   logic [31:0] remainder;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
   } res_t;

   res_t        sb[$];
   int          npass  = 0;
   int          ntotal = 0;
   int          nfail  = 0;
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;
   int          zero_lat;

   div_unit #(.WIDTH(32)) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .start_i      (start),
      .signed_div_i (signed_div),
      .dividend_i   (dividend),
      .divisor_i    (divisor),
      .annul_i      (annul),
      .busy_o       (busy),
      .ready_o      (ready),
      .quotient_o   (quotient),
      .remainder_o  (remainder)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
      res_t   m;
      longint sa;
      longint sb2;
      if (b == 32'd0) begin
         m.q = '0;
         m.r = '0;
      end else if (s) begin
         sa  = longint'($signed(a));
         sb2 = longint'($signed(b));
         m.q = 32'(sa / sb2);
         m.r = 32'(sa % sb2);
      end else begin
         m.q = a / b;
         m.r = a % b;
      end
      return m;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Drive a request for one cycle; returns one cycle later (cycle 1).
   task automatic drive_start(input logic [31:0] a, input logic [31:0] b,
                              input logic s, input bit push);
      start      = 1'b1;
      dividend   = a;
      divisor    = b;
      signed_div = s;
      if (push) sb.push_back(model(a, b, s));
      step();
      start      = 1'b0;
      dividend   = 32'hDEAD_BEEF;
      divisor    = 32'h0000_0003;
      signed_div = ~s;
   endtask

   // Wait for ready (current cycle = first_cyc), check latency, busy cycles
   // and the scoreboard head. Returns while still in the ready cycle.
   task automatic wait_ready(input string tag, input int exp_lat, input int first_cyc);
      int   cyc   = first_cyc;
      int   nbusy = 0;
      bit   got   = 0;
      res_t e;
      while (cyc <= 80) begin
         if (ready) begin
            got = 1;
            break;
         end
         if (busy) nbusy++;
         step();
         cyc++;
      end
      check({tag, "_latency"}, got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_lat));
      check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat - first_cyc));
      if (got) begin
         check({tag, "_busy_at_ready"}, {31'd0, busy}, 32'd0);
         if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            check({tag, "_q"}, quotient, e.q);
            check({tag, "_r"}, remainder, e.r);
            last_q = e.q;
            last_r = e.r;
         end
      end
   endtask

   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int lat);
      drive_start(a, b, s, 1'b1);
      wait_ready(tag, lat, 1);
   endtask

   initial begin
      int nready;
`ifdef DIV_ZERO_EARLY_OUT_EN
      zero_lat = 2;
`else
      zero_lat = 33;
`endif
      rstn = 1'b0; start = 1'b0; signed_div = 1'b0;
      dividend = '0; divisor = '0; annul = 1'b0;
      step(); step();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_q", quotient, 32'd0);
      check("rst_r", remainder, 32'd0);
      rstn = 1'b1;
      step();

      // Basic unsigned, plus one-cycle ready pulse.
      do_div("u100_7", 32'd100, 32'd7, 1'b0, 33);
      step();
      check("ready_pulse_width", {31'd0, ready}, 32'd0);
      check("hold_q", quotient, last_q);

      do_div("s_m7_2",   32'hFFFF_FFF9, 32'd2,          1'b1, 33);
      do_div("s_ovf",    32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 33);
      do_div("u_ffff_1", 32'hFFFF_FFFF, 32'd1,          1'b0, 33);
      do_div("u_small",  32'd3,         32'hFFFF_FFFF,  1'b0, 33);
      do_div("s_7_m2",   32'd7,         32'hFFFF_FFFE,  1'b1, 33);
      do_div("u_5_0",    32'd5,         32'd0,          1'b0, zero_lat);
      do_div("s_m5_0",   32'hFFFF_FFFB, 32'd0,          1'b1, zero_lat);
      for (int i = 0; i < 4; i++) begin
         do_div("rand", $urandom, $urandom_range(1, 32'hFFFF), 1'(i & 1), 33);
      end

      // Annul mid-divide: 9/3 started, annul in cycle 10, new start in cycle 12.
      drive_start(32'd9, 32'd3, 1'b0, 1'b0);
      for (int i = 1; i < 10; i++) step();
      annul = 1'b1;
      step();
      annul = 1'b0;
      check("annul_busy", {31'd0, busy}, 32'd0);
      check("annul_ready", {31'd0, ready}, 32'd0);
      check("annul_hold_q", quotient, last_q);
      check("annul_hold_r", remainder, last_r);
      step();
      drive_start(32'd20, 32'd6, 1'b0, 1'b1);
      wait_ready("after_annul", 45, 13);

      // Start while busy is ignored; start in DONE is accepted back-to-back.
      step();
      drive_start(32'd1000, 32'd10, 1'b0, 1'b1);
      for (int i = 1; i < 5; i++) step();
      start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      step();
      start = 1'b0;
      wait_ready("busy_start", 33, 6);
      drive_start(32'd77, 32'd4, 1'b0, 1'b1);
      wait_ready("b2b", 33, 1);

      // Reset in cycle 15 of a divide.
      step();
      drive_start(32'd123456, 32'd789, 1'b1, 1'b0);
      for (int i = 1; i < 15; i++) step();
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_ready", {31'd0, ready}, 32'd0);
      check("midrst_q", quotient, 32'd0);
      check("midrst_r", remainder, 32'd0);
      nready = 0;
      for (int i = 0; i < 40; i++) begin
         if (ready || busy) nready++;
         step();
      end
      check("midrst_no_ready", 32'(nready), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rstn  input  1  Reset, synchronous, active-low.
REQ-004 start  input  1  Request from EXE stage; sampled only when not busy.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 dividend  input  32  Operand A; sampled with start.
REQ-007 divisor  input  32  Operand B; sampled with start.
REQ-008 annul  input  1  Abort in-flight divide (pipeline flush/exception).
REQ-009 busy  output  1  High while a divide is in flight.
REQ-010 ready  output  1  One-cycle pulse; results valid.
REQ-011 quotient  output  32  Registered LO value.
REQ-012 remainder  output  32  Registered HI value.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC, ZERO and DONE; busy SHALL equal (state==CALC or state==ZERO); ready SHALL equal (state==DONE).
REQ-014 start with annul low, sampled in IDLE or DONE: SHALL latch the operands and sign mode, enter CALC with counter 0, or enter ZERO if the ZERO path is enabled (REQ-024) and divisor==0.
REQ-015 start while busy SHALL be ignored; operand inputs SHALL not affect the in-flight divide.
REQ-016 CALC SHALL perform one restoring radix-2 iteration per cycle on the operand magnitudes, 32 iterations, with a 6-bit counter; the final iteration SHALL transition to DONE.
REQ-017 Latency, with the start cycle as cycle 0: ready SHALL be high in cycle 33 only.
REQ-018 Signed mode: the quotient SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign; 0x80000000 / 0xFFFFFFFF SHALL give q=0x80000000, r=0.
REQ-019 Divisor==0 SHALL give q=0 and r=0 in both modes.
REQ-020 quotient and remainder SHALL update only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-021 DONE SHALL return to IDLE after one cycle, unless start is sampled in that cycle (back-to-back accepted).
REQ-022 annul high in CALC or ZERO SHALL force IDLE at the next edge, with no ready and outputs unchanged; annul SHALL take priority over a simultaneous start; annul in IDLE or DONE SHALL only block start.

Reset
REQ-023 rstn low at any edge, including mid-divide, SHALL force IDLE, counter 0, busy=0, ready=0, quotient=0 and remainder=0; any in-flight divide SHALL be dropped without ready.

Configuration
REQ-024 Macro DIV_ZERO_EARLY_OUT_EN defined: divisor==0 SHALL take the ZERO state for one cycle, with ready in cycle 2 (start cycle 0). Macro undefined: ZERO SHALL be unreachable, divisor==0 SHALL run the full CALC with results forced per REQ-019, and ready SHALL be in cycle 33.

Verification
REQ-025 Unsigned: 100/7 -> q=14, r=2; ready in cycle 33 only; busy high in cycles 1-32.
REQ-026 Signed: -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. Signed: 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
REQ-027 Divide by zero: 5/0 -> q=0, r=0; ready in cycle 2 with DIV_ZERO_EARLY_OUT_EN, in cycle 33 without.
REQ-028 Unsigned 9/3 started, then annul in cycle 10 -> IDLE in cycle 11, no ready, outputs hold previous values; new start 20/6 in cycle 12 -> q=3, r=2 in cycle 45.
REQ-029 start 50/5 while busy in cycle 5 -> ignored, first result unchanged; start in the DONE cycle -> accepted, next ready exactly 33 cycles later.
REQ-030 rstn low in cycle 15 of a divide -> from the following cycle busy=0, ready=0, quotient=0, remainder=0, and no ready follows.
